ma_channel_scheduler: RTL and testbench

MA_CHANNEL_SCHEDULER -- requirements
Module: ma_channel_scheduler

---
 rtl/ma_sched_pkg.sv | 23 ++
 rtl/ma_channel_scheduler_arb.sv | 46 ++++
 rtl/ma_channel_scheduler.sv | 124 ++++++++++++
 tb/tb_ma_channel_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_sched_pkg.sv
// Shared types and width helpers for the moving-average channel scheduler.
// Per-channel state fields are sized for the largest supported window.
package ma_sched_pkg;

  localparam int SUM_MAX_W = 48;
  localparam int CNT_MAX_W = 16;

  typedef struct packed {
    logic [SUM_MAX_W-1:0] sum;
    logic [CNT_MAX_W-1:0] wp;
    logic [CNT_MAX_W-1:0] fill;
  } ch_state_t;

  // DEPTH full-scale samples always fit in DATA_W + clog2(DEPTH) bits.
  function automatic int sum_width(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

  function automatic int idx_width(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/ma_channel_scheduler_arb.sv
// Round-robin arbiter: one-hot grant, priority restarts just after the last winner.
module ma_rr_arbiter
  import ma_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic          found;

  // Scan requesters in order ptr, ptr+1, ... using constant indices only.
  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (!found && req[j] && (((int'(ptr) + i) % N) == j)) begin
            gnt[j]   = 1'b1;
            found    = 1'b1;
            ptr_next = (j == N - 1) ? '0 : IW'(j + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/ma_channel_scheduler.sv
// Multi-channel moving-average engine sharing one accumulate/divide datapath.
// Optional MA_SCHED_WARMUP_EN suppresses outputs until a channel window is full.
module ma_channel_scheduler
  import ma_sched_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CH_NUM-1:0]             s_valid,
  input  logic [CH_NUM*DATA_W-1:0]      s_data,
  output logic [CH_NUM-1:0]             s_ready,
  input  logic [CH_NUM-1:0]             ch_clr,
  output logic                          m_valid,
  output logic [DATA_W-1:0]             m_data,
  output logic [idx_width(CH_NUM)-1:0]  m_ch,
  input  logic                          m_ready
);

  localparam int SUM_W = sum_width(DATA_W, DEPTH);
  localparam int IW    = idx_width(CH_NUM);

  ch_state_t         st   [CH_NUM];
  logic [DATA_W-1:0] hist [CH_NUM][DEPTH];

  logic [CH_NUM-1:0]    req;
  logic [CH_NUM-1:0]    gnt;
  logic                 arb_en;
  logic                 xfer;
  ch_state_t            cur;
  logic [DATA_W-1:0]    x;
  logic [DATA_W-1:0]    old;
  logic [IW-1:0]        gidx;
  logic [SUM_W-1:0]     sum_new;
  logic [CNT_MAX_W-1:0] wp_next;
  logic [CNT_MAX_W-1:0] fill_next;

  assign req     = s_valid & ~ch_clr;
  assign arb_en  = !rst && (!m_valid || m_ready);
  assign s_ready = gnt;
  assign xfer    = |gnt;

  ma_rr_arbiter #(
    .N (CH_NUM)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Steer the granted channel's state, sample and outgoing history entry.
  always_comb begin
    cur  = '0;
    x    = '0;
    old  = '0;
    gidx = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (gnt[k]) begin
        cur  = st[k];
        x    = s_data[k*DATA_W +: DATA_W];
        gidx = IW'(k);
        for (int j = 0; j < DEPTH; j++) begin
          if (st[k].wp == CNT_MAX_W'(j)) begin
            old = hist[k][j];
          end
        end
      end
    end
  end

  assign sum_new   = SUM_W'(cur.sum + SUM_MAX_W'(x) - SUM_MAX_W'(old));
  assign wp_next   = (cur.wp == CNT_MAX_W'(DEPTH - 1)) ? '0 : cur.wp + CNT_MAX_W'(1);
  assign fill_next = (cur.fill == CNT_MAX_W'(DEPTH)) ? cur.fill : cur.fill + CNT_MAX_W'(1);

  // Window state update and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        st[k] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          hist[k][j] <= '0;
        end
      end
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (ch_clr[k]) begin
          st[k] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            hist[k][j] <= '0;
          end
        end else if (gnt[k]) begin
          st[k].sum  <= SUM_MAX_W'(sum_new);
          st[k].wp   <= wp_next;
          st[k].fill <= fill_next;
          for (int j = 0; j < DEPTH; j++) begin
            if (cur.wp == CNT_MAX_W'(j)) begin
              hist[k][j] <= x;
            end
          end
        end
      end

      if (xfer) begin
`ifdef MA_SCHED_WARMUP_EN
        m_valid <= (fill_next == CNT_MAX_W'(DEPTH));
`else
        m_valid <= 1'b1;
`endif
        m_data  <= DATA_W'(sum_new / SUM_W'(DEPTH));
        m_ch    <= gidx;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Self-checking bench for ma_channel_scheduler with a queue-based window model.
module tb_ma_channel_scheduler;

  localparam int CH    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
`ifdef MA_SCHED_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    s_valid;
  logic [CH*DW-1:0] s_data;
  logic [CH-1:0]    s_ready;
  logic [CH-1:0]    ch_clr;
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic [1:0]       m_ch;
  logic             m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last DEPTH samples per channel, round-robin start, output slot.
  int            win [CH][$];
  int            ptr;
  logic          exp_mv;
  int            exp_md;
  int            exp_mc;
  logic [CH-1:0] obs_rdy;
  logic [CH-1:0] exp_rdy;

  ma_channel_scheduler #(
    .CH_NUM (CH),
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .ch_clr  (ch_clr),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ch    (m_ch),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, sample s_ready, advance model at posedge, return at negedge.
  task automatic cycle(input logic r, input logic [CH-1:0] sv, input logic [CH*DW-1:0] sd,
                       input logic [CH-1:0] clr, input logic mr);
    int g;
    int s;
    int c;
    rst = r; s_valid = sv; s_data = sd; ch_clr = clr; m_ready = mr;
    #1;
    obs_rdy = s_ready;
    g = -1;
    if (!r && !(exp_mv && !mr)) begin
      for (int i = 0; i < CH; i++) begin
        c = (ptr + i) % CH;
        if (g < 0 && sv[c] && !clr[c]) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (CH'(1) << g) : '0;
    @(posedge clk);
    if (r) begin
      ptr = 0;
      for (int k = 0; k < CH; k++) win[k].delete();
      exp_mv = 1'b0; exp_md = 0; exp_mc = 0;
    end else begin
      for (int k = 0; k < CH; k++) if (clr[k]) win[k].delete();
      if (g >= 0) begin
        win[g].push_back(int'(sd[g*DW +: DW]));
        if (win[g].size() > DEPTH) void'(win[g].pop_front());
        s = 0;
        foreach (win[g][i]) s += win[g][i];
        exp_mv = WARM ? (win[g].size() == DEPTH) : 1'b1;
        exp_md = s / DEPTH;
        exp_mc = g;
        ptr    = (g + 1) % CH;
      end else if (mr) begin
        exp_mv = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'hF, $urandom, 4'h0, 1'b1);
      n_checks++;
      if (obs_rdy !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready got=%b want=0000", obs_rdy);
      end
    end
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'd0 || m_ch !== 2'd0) begin
      n_fail++; $display("FAIL reset_out got v=%b d=%0d ch=%0d want 0/0/0", m_valid, m_data, m_ch);
    end
  endtask

  task automatic test_ramp();
    int got[$];
    int want[$];
    cycle(1'b1, 4'h0, '0, 4'h0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 4'b0001, {24'd0, 8'(4 * i)}, 4'h0, 1'b1);
      n_checks++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL ramp_ready i=%0d got=%b want=%b", i, obs_rdy, exp_rdy);
      end
      n_checks++;
      if (m_valid !== exp_mv) begin
        n_fail++; $display("FAIL ramp_valid i=%0d got=%b want=%b", i, m_valid, exp_mv);
      end
      if (m_valid) got.push_back(int'(m_data));
      if (exp_mv) begin
        n_checks++;
        if (m_data !== 8'(exp_md) || m_ch !== 2'd0) begin
          n_fail++; $display("FAIL ramp_data i=%0d got=%0d/ch%0d want=%0d/ch0", i, m_data, m_ch, exp_md);
        end
      end
    end
`ifdef MA_SCHED_WARMUP_EN
    want = '{10, 14};
`else
    want = '{1, 3, 6, 10, 14};
`endif
    n_checks++;
    if (got != want) begin
      n_fail++; $display("FAIL ramp_sequence got=%p want=%p", got, want);
    end
  endtask

  task automatic test_all_valid();
    cycle(1'b1, 4'h0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 4'hF, $urandom, 4'h0, 1'b1);
      n_checks++;
      if (obs_rdy !== (4'b0001 << (i % 4)) || obs_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant i=%0d got=%b want=%b", i, obs_rdy, 4'b0001 << (i % 4));
      end
      n_checks++;
      if (m_valid !== exp_mv) begin
        n_fail++; $display("FAIL rr_valid i=%0d got=%b want=%b", i, m_valid, exp_mv);
      end
      if (exp_mv) begin
        n_checks++;
        if (m_ch !== 2'(i % 4) || m_data !== 8'(exp_md)) begin
          n_fail++; $display("FAIL rr_out i=%0d got=%0d/ch%0d want=%0d/ch%0d", i, m_data, m_ch, exp_md, i % 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_d;
    logic [1:0]    held_c;
    logic [CH-1:0] seen;
    cycle(1'b1, 4'h0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0100, {8'd0, 8'd40, 16'd0}, 4'h0, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'd40 || m_ch !== 2'd2) begin
      n_fail++; $display("FAIL bp_setup got v=%b d=%0d ch=%0d want 1/40/2", m_valid, m_data, m_ch);
    end
    held_d = m_data; held_c = m_ch;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b1010, {8'd9, 8'd0, 8'd7, 8'd0}, 4'h0, 1'b0);
      n_checks++;
      if (obs_rdy !== 4'b0000 || m_valid !== 1'b1 || m_data !== held_d || m_ch !== held_c) begin
        n_fail++; $display("FAIL bp_hold i=%0d got rdy=%b v=%b d=%0d ch=%0d want 0000/1/%0d/%0d",
                           i, obs_rdy, m_valid, m_data, m_ch, held_d, held_c);
      end
    end
    seen = '0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b1010 & ~seen, {8'd9, 8'd0, 8'd7, 8'd0}, 4'h0, 1'b1);
      seen |= obs_rdy;
      n_checks++;
      if (obs_rdy !== exp_rdy || m_valid !== exp_mv) begin
        n_fail++; $display("FAIL bp_release i=%0d got rdy=%b v=%b want %b/%b", i, obs_rdy, m_valid, exp_rdy, exp_mv);
      end
      if (exp_mv) begin
        n_checks++;
        if (m_data !== 8'(exp_md) || m_ch !== 2'(exp_mc)) begin
          n_fail++; $display("FAIL bp_data i=%0d got=%0d/ch%0d want=%0d/ch%0d", i, m_data, m_ch, exp_md, exp_mc);
        end
      end
    end
    n_checks++;
    if (seen !== 4'b1010) begin
      n_fail++; $display("FAIL bp_no_loss got=%b want=1010", seen);
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 4'h0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'b0100, {8'd0, 8'd20, 16'd0}, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0010, {16'd0, 8'd10, 8'd0}, 4'h0, 1'b1);
    cycle(1'b0, 4'b0010, {16'd0, 8'd99, 8'd0}, 4'b0010, 1'b0);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'd10 || m_ch !== 2'd1) begin
      n_fail++; $display("FAIL clr_keeps_out got v=%b d=%0d ch=%0d want 1/10/1", m_valid, m_data, m_ch);
    end
    cycle(1'b0, 4'b0010, {16'd0, 8'd99, 8'd0}, 4'b0010, 1'b1);
    n_checks++;
    if (obs_rdy[1] !== 1'b0 || obs_rdy !== exp_rdy) begin
      n_fail++; $display("FAIL clr_no_grant got=%b want=%b", obs_rdy, exp_rdy);
    end
    cycle(1'b0, 4'b0010, {16'd0, 8'd8, 8'd0}, 4'h0, 1'b1);
    n_checks++;
    if (obs_rdy !== 4'b0010 || m_valid !== exp_mv) begin
      n_fail++; $display("FAIL clr_ch1_xfer got rdy=%b v=%b want 0010/%b", obs_rdy, m_valid, exp_mv);
    end
`ifndef MA_SCHED_WARMUP_EN
    n_checks++;
    if (m_data !== 8'd2 || m_ch !== 2'd1) begin
      n_fail++; $display("FAIL clr_ch1_avg got=%0d/ch%0d want=2/ch1", m_data, m_ch);
    end
`endif
    cycle(1'b0, 4'b0100, {8'd0, 8'd20, 16'd0}, 4'h0, 1'b1);
    n_checks++;
    if (m_valid !== exp_mv || (exp_mv && (m_data !== 8'(exp_md) || m_ch !== 2'd2))) begin
      n_fail++; $display("FAIL clr_ch2_avg got v=%b d=%0d ch=%0d want %b/%0d/2", m_valid, m_data, m_ch, exp_mv, exp_md);
    end
`ifndef MA_SCHED_WARMUP_EN
    n_checks++;
    if (m_data !== 8'd15) begin
      n_fail++; $display("FAIL clr_ch2_const got=%0d want=15", m_data);
    end
`endif
  endtask

  task automatic test_saturate();
    cycle(1'b1, 4'h0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'b1000, {8'd255, 24'd0}, 4'h0, 1'b1);
      n_checks++;
      if (m_valid !== exp_mv || (exp_mv && (m_data !== 8'(exp_md) || m_ch !== 2'd3))) begin
        n_fail++; $display("FAIL sat_model i=%0d got v=%b d=%0d want %b/%0d", i, m_valid, m_data, exp_mv, exp_md);
      end
      if (i >= 3) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd255) begin
          n_fail++; $display("FAIL sat_full i=%0d got v=%b d=%0d want 1/255", i, m_valid, m_data);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 4'h0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0001, {24'd0, 8'd100}, 4'h0, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'd100) begin
      n_fail++; $display("FAIL mrst_setup got v=%b d=%0d want 1/100", m_valid, m_data);
    end
    cycle(1'b1, 4'hF, $urandom, 4'h0, 1'b0);
    n_checks++;
    if (obs_rdy !== 4'b0000 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL mrst_drop got rdy=%b v=%b want 0000/0", obs_rdy, m_valid);
    end
    cycle(1'b0, 4'b0001, {24'd0, 8'd4}, 4'h0, 1'b1);
    n_checks++;
    if (obs_rdy !== 4'b0001 || m_valid !== exp_mv || (exp_mv && m_data !== 8'(exp_md))) begin
      n_fail++; $display("FAIL mrst_after got rdy=%b v=%b d=%0d want 0001/%b/%0d", obs_rdy, m_valid, m_data, exp_mv, exp_md);
    end
`ifndef MA_SCHED_WARMUP_EN
    n_checks++;
    if (m_data !== 8'd1 || m_ch !== 2'd0) begin
      n_fail++; $display("FAIL mrst_const got=%0d/ch%0d want=1/ch0", m_data, m_ch);
    end
`endif
  endtask

  task automatic test_random();
    logic          r;
    logic [CH-1:0] clr;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
      cycle(r, CH'($urandom), $urandom, clr, ($urandom_range(0, 3) != 0));
      n_checks++;
      if (obs_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready i=%0d got=%b want=%b", i, obs_rdy, exp_rdy);
      end
      n_checks++;
      if (m_valid !== exp_mv) begin
        n_fail++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, m_valid, exp_mv);
      end
      if (exp_mv) begin
        n_checks++;
        if (m_data !== 8'(exp_md) || m_ch !== 2'(exp_mc)) begin
          n_fail++; $display("FAIL rand_data i=%0d got=%0d/ch%0d want=%0d/ch%0d", i, m_data, m_ch, exp_md, exp_mc);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = '0; s_data = '0; ch_clr = '0; m_ready = 1'b1;
    ptr = 0; exp_mv = 1'b0; exp_md = 0; exp_mc = 0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_all_valid();
    test_backpressure();
    test_clear();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
